// File: rtl/snake_board_reader.sv
// Read-side engine for the 16x16 snake board: full-board occupancy sweep plus single-cell lookup.
// Define SNAKE_READER_HEAD_TRACK_EN to also locate the first head (11) cell during a sweep.
module snake_board_reader #(
  parameter int unsigned GRID_BITS = 4,
  parameter int unsigned CELL_BITS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2*GRID_BITS-1:0] seed,
  input  logic                   query_valid,
  input  logic [GRID_BITS-1:0]   query_x,
  input  logic [GRID_BITS-1:0]   query_y,
  output logic [GRID_BITS-1:0]   mem_x,
  output logic [GRID_BITS-1:0]   mem_y,
  input  logic [CELL_BITS-1:0]   mem_data,
  output logic                   busy,
  output logic                   done,
  output logic [2*GRID_BITS:0]   snake_count,
  output logic [2*GRID_BITS:0]   free_count,
  output logic                   food_found,
  output logic [GRID_BITS-1:0]   food_x,
  output logic [GRID_BITS-1:0]   food_y,
  output logic                   query_done,
  output logic [CELL_BITS-1:0]   query_data,
  output logic                   head_found,
  output logic [GRID_BITS-1:0]   head_x,
  output logic [GRID_BITS-1:0]   head_y
);

  localparam int unsigned IdxW = 2 * GRID_BITS;
  localparam int unsigned CntW = IdxW + 1;
  localparam logic [CELL_BITS-1:0] CellFree = '0;
  localparam logic [CELL_BITS-1:0] CellBody = CELL_BITS'(1);
  localparam logic [CELL_BITS-1:0] CellHead = CELL_BITS'(3);

  typedef enum logic [1:0] {StIdle, StScan, StQuery, StFinish} state_e;

  state_e              state_q, state_d;
  logic                scan_mode_q, scan_mode_d;
  logic [IdxW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     addr_q, addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                query_done_q, query_done_d;
  logic [CELL_BITS-1:0] query_data_q, query_data_d;

  // cap_q marks a cycle whose mem_data belongs to sweep cell cap_idx_q
  logic                cap_q, cap_d;
  logic [IdxW-1:0]     cap_idx_q, cap_idx_d;

  logic [CntW-1:0]     free_acc_q, free_acc_d;
  logic [CntW-1:0]     snake_acc_q, snake_acc_d;
  logic                food_hit_q, food_hit_d;
  logic [IdxW-1:0]     food_idx_q, food_idx_d;

  logic [CntW-1:0]     free_count_q, free_count_d;
  logic [CntW-1:0]     snake_count_q, snake_count_d;
  logic                food_found_q, food_found_d;
  logic [IdxW-1:0]     food_pub_q, food_pub_d;

`ifdef SNAKE_READER_HEAD_TRACK_EN
  logic                head_hit_q, head_hit_d;
  logic [IdxW-1:0]     head_idx_q, head_idx_d;
  logic                head_found_q, head_found_d;
  logic [IdxW-1:0]     head_pub_q, head_pub_d;
`endif

  always_comb begin
    state_d       = state_q;
    scan_mode_d   = scan_mode_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    done_d        = 1'b0;
    query_done_d  = 1'b0;
    query_data_d  = query_data_q;
    cap_d         = 1'b0;
    cap_idx_d     = addr_q;
    free_acc_d    = free_acc_q;
    snake_acc_d   = snake_acc_q;
    food_hit_d    = food_hit_q;
    food_idx_d    = food_idx_q;
    free_count_d  = free_count_q;
    snake_count_d = snake_count_q;
    food_found_d  = food_found_q;
    food_pub_d    = food_pub_q;
`ifdef SNAKE_READER_HEAD_TRACK_EN
    head_hit_d    = head_hit_q;
    head_idx_d    = head_idx_q;
    head_found_d  = head_found_q;
    head_pub_d    = head_pub_q;
`endif

    if (cap_q) begin
      if (mem_data == CellFree) begin
        free_acc_d = free_acc_q + CntW'(1);
        if (!food_hit_q) begin
          food_hit_d = 1'b1;
          food_idx_d = cap_idx_q;
        end
      end else if ((mem_data == CellBody) || (mem_data == CellHead)) begin
        snake_acc_d = snake_acc_q + CntW'(1);
      end
`ifdef SNAKE_READER_HEAD_TRACK_EN
      if ((mem_data == CellHead) && !head_hit_q) begin
        head_hit_d = 1'b1;
        head_idx_d = cap_idx_q;
      end
`endif
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StScan;
          scan_mode_d = 1'b1;
          cnt_d       = '0;
          addr_d      = seed;
          free_acc_d  = '0;
          snake_acc_d = '0;
          food_hit_d  = 1'b0;
          food_idx_d  = '0;
`ifdef SNAKE_READER_HEAD_TRACK_EN
          head_hit_d  = 1'b0;
          head_idx_d  = '0;
`endif
        end else if (query_valid) begin
          state_d     = StQuery;
          scan_mode_d = 1'b0;
          addr_d      = {query_y, query_x};
        end
      end
      StScan: begin
        cap_d = 1'b1;
        if (cnt_q == '1) begin
          state_d = StFinish;
          addr_d  = '0;
        end else begin
          cnt_d  = cnt_q + IdxW'(1);
          addr_d = addr_q + IdxW'(1);
        end
      end
      StQuery: begin
        state_d = StFinish;
        addr_d  = '0;
      end
      StFinish: begin
        // Last sweep cell (or lookup data) arrives here; publish the merged next values.
        state_d = StIdle;
        if (scan_mode_q) begin
          done_d        = 1'b1;
          free_count_d  = free_acc_d;
          snake_count_d = snake_acc_d;
          food_found_d  = food_hit_d;
          food_pub_d    = food_idx_d;
`ifdef SNAKE_READER_HEAD_TRACK_EN
          head_found_d  = head_hit_d;
          head_pub_d    = head_idx_d;
`endif
        end else begin
          query_done_d = 1'b1;
          query_data_d = mem_data;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      scan_mode_q   <= 1'b0;
      cnt_q         <= '0;
      addr_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      query_done_q  <= 1'b0;
      query_data_q  <= '0;
      cap_q         <= 1'b0;
      cap_idx_q     <= '0;
      free_acc_q    <= '0;
      snake_acc_q   <= '0;
      food_hit_q    <= 1'b0;
      food_idx_q    <= '0;
      free_count_q  <= '0;
      snake_count_q <= '0;
      food_found_q  <= 1'b0;
      food_pub_q    <= '0;
`ifdef SNAKE_READER_HEAD_TRACK_EN
      head_hit_q    <= 1'b0;
      head_idx_q    <= '0;
      head_found_q  <= 1'b0;
      head_pub_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      scan_mode_q   <= scan_mode_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      query_done_q  <= query_done_d;
      query_data_q  <= query_data_d;
      cap_q         <= cap_d;
      cap_idx_q     <= cap_idx_d;
      free_acc_q    <= free_acc_d;
      snake_acc_q   <= snake_acc_d;
      food_hit_q    <= food_hit_d;
      food_idx_q    <= food_idx_d;
      free_count_q  <= free_count_d;
      snake_count_q <= snake_count_d;
      food_found_q  <= food_found_d;
      food_pub_q    <= food_pub_d;
`ifdef SNAKE_READER_HEAD_TRACK_EN
      head_hit_q    <= head_hit_d;
      head_idx_q    <= head_idx_d;
      head_found_q  <= head_found_d;
      head_pub_q    <= head_pub_d;
`endif
    end
  end

  assign mem_x       = addr_q[GRID_BITS-1:0];
  assign mem_y       = addr_q[IdxW-1:GRID_BITS];
  assign busy        = busy_q;
  assign done        = done_q;
  assign snake_count = snake_count_q;
  assign free_count  = free_count_q;
  assign food_found  = food_found_q;
  assign food_x      = food_pub_q[GRID_BITS-1:0];
  assign food_y      = food_pub_q[IdxW-1:GRID_BITS];
  assign query_done  = query_done_q;
  assign query_data  = query_data_q;

`ifdef SNAKE_READER_HEAD_TRACK_EN
  assign head_found  = head_found_q;
  assign head_x      = head_pub_q[GRID_BITS-1:0];
  assign head_y      = head_pub_q[IdxW-1:GRID_BITS];
`else
  assign head_found  = 1'b0;
  assign head_x      = '0;
  assign head_y      = '0;
`endif

endmodule

// File: tb/tb_snake_board_reader.sv
// Bench for snake_board_reader: fixed board vectors, timing sequences and random boards vs a model.
module tb_snake_board_reader;

  logic       clk = 1'b0;
  logic       reset, start, query_valid;
  logic [7:0] seed;
  logic [3:0] query_x, query_y, mem_x, mem_y, food_x, food_y, head_x, head_y;
  logic [1:0] mem_data, query_data;
  logic       busy, done, food_found, query_done, head_found;
  logic [8:0] snake_count, free_count;

  logic [1:0] board [256];
  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  // Board memory with 1-cycle read latency
  always @(posedge clk) mem_data <= board[{mem_y, mem_x}];

  snake_board_reader dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed),
    .query_valid(query_valid), .query_x(query_x), .query_y(query_y),
    .mem_x(mem_x), .mem_y(mem_y), .mem_data(mem_data),
    .busy(busy), .done(done), .snake_count(snake_count), .free_count(free_count),
    .food_found(food_found), .food_x(food_x), .food_y(food_y),
    .query_done(query_done), .query_data(query_data),
    .head_found(head_found), .head_x(head_x), .head_y(head_y)
  );

  typedef struct {
    int free_n;
    int snake_n;
    bit found;
    int food;
    bit hfound;
    int head;
  } exp_t;

  typedef struct {
    logic [1:0] fill;
    logic [7:0] hole;
    logic [1:0] hole_val;
    logic [7:0] seed;
    exp_t       e;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walk the board in wrapped linear order from the seed
  function automatic exp_t model(input logic [7:0] s);
    exp_t e = '{0, 0, 1'b0, 0, 1'b0, 0};
    for (int k = 0; k < 256; k++) begin
      int idx = (int'(s) + k) % 256;
      logic [1:0] v = board[idx];
      if (v == 2'b00) begin
        e.free_n++;
        if (!e.found) begin e.found = 1'b1; e.food = idx; end
      end
      if (v == 2'b01 || v == 2'b11) e.snake_n++;
      if (v == 2'b11 && !e.hfound) begin e.hfound = 1'b1; e.head = idx; end
    end
    return e;
  endfunction

  task automatic run_sweep(input logic [7:0] s, input bit with_query, input exp_t e_in,
                           input string tag);
    exp_t e = e_in;
    int cyc = 1;
    int busy_lo = 0;
    int addr_bad = 0;
    int qd = 0;
`ifndef SNAKE_READER_HEAD_TRACK_EN
    e.hfound = 1'b0;
    e.head = 0;
`endif
    seed = s;
    start = 1'b1;
    if (with_query) begin
      query_valid = 1'b1;
      query_x = 4'd7;
      query_y = 4'd5;
    end
    step();
    start = 1'b0;
    query_valid = 1'b0;
    while (!done && cyc < 300) begin
      if (!busy) busy_lo++;
      if (query_done) qd++;
      if (cyc <= 256 && {mem_y, mem_x} != 8'((int'(s) + cyc - 1) % 256)) addr_bad++;
      step();
      cyc++;
    end
    check({tag, " done_cycle"}, cyc, 258);
    check({tag, " busy_gaps"}, busy_lo, 0);
    check({tag, " addr_seq_errs"}, addr_bad, 0);
    check({tag, " busy_at_done"}, busy, 0);
    check({tag, " free_count"}, free_count, e.free_n);
    check({tag, " snake_count"}, snake_count, e.snake_n);
    check({tag, " food_found"}, food_found, e.found);
    check({tag, " food_xy"}, {food_y, food_x}, e.food);
    check({tag, " head_found"}, head_found, e.hfound);
    check({tag, " head_xy"}, {head_y, head_x}, e.head);
    if (with_query) check({tag, " dropped_query_pulses"}, qd + int'(query_done), 0);
    step();
    check({tag, " done_single_pulse"}, done, 0);
  endtask

  task automatic run_query(input logic [3:0] x, input logic [3:0] y, input bit start_during,
                           input string tag);
    int bad = 0;
    query_x = x;
    query_y = y;
    query_valid = 1'b1;
    step();
    query_valid = 1'b0;
    check({tag, " busy_t1"}, busy, 1);
    check({tag, " addr_t1"}, {mem_y, mem_x}, {y, x});
    if (start_during) start = 1'b1;
    step();
    start = 1'b0;
    check({tag, " busy_t2"}, busy, 1);
    check({tag, " qdone_t2"}, query_done, 0);
    step();
    check({tag, " qdone_t3"}, query_done, 1);
    check({tag, " qdata"}, query_data, board[{y, x}]);
    check({tag, " busy_t3"}, busy, 0);
    step();
    check({tag, " qdone_t4"}, query_done, 0);
    if (start_during) begin
      for (int i = 0; i < 270; i++) begin
        if (done || busy) bad++;
        step();
      end
      check({tag, " ignored_start_activity"}, bad, 0);
    end
  endtask

  task automatic fill_board(input logic [1:0] v);
    for (int i = 0; i < 256; i++) board[i] = v;
  endtask

  initial begin
    int bad;
    exp_t e;
    vecs[0] = '{2'd0, 8'h00, 2'd0, 8'h00, '{256, 0, 1'b1, 8'h00, 1'b0, 0}};
    vecs[1] = '{2'd1, 8'h23, 2'd0, 8'h40, '{1, 255, 1'b1, 8'h23, 1'b0, 0}};
    vecs[2] = '{2'd2, 8'h00, 2'd2, 8'h37, '{0, 0, 1'b0, 0, 1'b0, 0}};
    vecs[3] = '{2'd3, 8'h3F, 2'd0, 8'h40, '{1, 255, 1'b1, 8'h3F, 1'b1, 8'h40}};
    vecs[4] = '{2'd0, 8'h10, 2'd3, 8'hFF, '{255, 1, 1'b1, 8'hFF, 1'b1, 8'h10}};

    fill_board(2'd0);
    reset = 1'b1;
    start = 1'b0;
    query_valid = 1'b0;
    seed = 8'h00;
    query_x = 4'd0;
    query_y = 4'd0;
    step();
    step();
    step();
    reset = 1'b0;
    step();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset counts", {snake_count, free_count}, 0);
    check("reset food", {food_found, food_y, food_x}, 0);
    check("reset query", {query_done, query_data}, 0);
    check("reset head", {head_found, head_y, head_x}, 0);
    check("reset mem_addr", {mem_y, mem_x}, 0);

    foreach (vecs[i]) begin
      fill_board(vecs[i].fill);
      board[vecs[i].hole] = vecs[i].hole_val;
      run_sweep(vecs[i].seed, 1'b0, vecs[i].e, $sformatf("vec%0d", i));
    end

    // Small snake: body (5,5),(6,5), head (7,5), food (9,9)
    fill_board(2'd0);
    board[8'h55] = 2'd1;
    board[8'h56] = 2'd1;
    board[8'h57] = 2'd3;
    board[8'h99] = 2'd2;
    run_sweep(8'h55, 1'b0, '{252, 3, 1'b1, 8'h58, 1'b1, 8'h57}, "snake");
    run_query(4'd7, 4'd5, 1'b1, "lookup_head");
    check("published_hold snake_count", snake_count, 3);
    check("published_hold food_xy", {food_y, food_x}, 8'h58);

    run_sweep(8'h00, 1'b1, model(8'h00), "start_and_query");

    // Reset in the middle of a sweep
    seed = 8'h10;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i < 100; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset busy", busy, 0);
    check("midreset counts", {snake_count, free_count}, 0);
    check("midreset food", {food_found, food_y, food_x}, 0);
    check("midreset head", {head_found, head_y, head_x}, 0);
    bad = 0;
    for (int i = 0; i < 270; i++) begin
      if (done || busy || query_done) bad++;
      step();
    end
    check("midreset no_activity", bad, 0);
    run_sweep(8'h10, 1'b0, model(8'h10), "after_reset");

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 256; i++) begin
        case (r % 3)
          0: board[i] = 2'($urandom_range(0, 3));
          1: board[i] = ($urandom_range(0, 99) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
          default: board[i] = 2'($urandom_range(1, 3));
        endcase
      end
      seed = 8'($urandom);
      e = model(seed);
      run_sweep(seed, 1'b0, e, $sformatf("rand%0d", r));
      for (int q = 0; q < 3; q++)
        run_query(4'($urandom), 4'($urandom), 1'b0, $sformatf("rand%0d_q%0d", r, q));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
